// File: rtl/reg_pipe_stage_if.sv
// reg_pipe_stage_if -- upstream/downstream handshake bundle for reg_pipe_stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and data stable until the transfer; ready
// may depend on the consumer's state but a transfer is never retracted.
interface reg_pipe_stage_if #(
    parameter int DATA_W = 229
);
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;

    // Environment side: offers upstream data and consumes downstream data.
    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    // Pipeline stage side.
    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );
endinterface

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage -- one-cycle registered pipeline stage with flush and a
// saturating count of entries discarded by flush.
// Build option: define PIPE_SKID_EN to add a skid register (2 entries,
// registered in_ready_o); leave it undefined for a single register with a
// combinational in_ready_o. Ports and parameters are the same in both builds.
module reg_pipe_stage #(
    parameter int DATA_W         = 229,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             flush_i,
    reg_pipe_stage_if.slave  bus,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [1:0]        r_occ;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [1:0]        w_occ_nxt;
    logic [CNT_W+1:0]  w_drop_sum;
    logic [CNT_W-1:0]  w_drop_nxt;

    // Flush wins over everything, so an offered input is not taken on a flush edge.
    assign w_in_fire  = bus.in_valid_i & w_in_ready & ~flush_i;
    assign w_out_fire = r_main_valid & bus.out_ready_i;

`ifdef PIPE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic [DATA_W-1:0] w_skid_data_nxt;

    // Ready only depends on skid occupancy, so it can come from a flop.
    assign w_in_ready = r_in_ready;

    // Next-state for main and skid: drain skid into main on every output transfer.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush_i) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                w_main_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                // in_ready is low while skid is full, so no input competes here.
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_main_data_nxt = bus.in_data_i;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_main_valid) begin
                w_skid_data_nxt  = bus.in_data_i;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_main_data_nxt  = bus.in_data_i;
                w_main_valid_nxt = 1'b1;
            end
        end
    end

    // Skid storage and the registered ready flag.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end
`else
    // Accept when empty or when the held entry leaves on this same edge.
    assign w_in_ready       = ~r_main_valid | bus.out_ready_i;
    assign w_skid_valid_nxt = 1'b0;

    // Next-state for the single register: load on input, empty on output.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        if (flush_i) begin
            w_main_valid_nxt = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                w_main_data_nxt = '0;
            end
        end else if (w_in_fire) begin
            w_main_data_nxt  = bus.in_data_i;
            w_main_valid_nxt = 1'b1;
        end else if (w_out_fire) begin
            w_main_valid_nxt = 1'b0;
        end
    end
`endif

    // Occupancy follows the valid bits it will hold after this edge.
    assign w_occ_nxt = {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};

    // Flush adds the current occupancy to the drop counter, clamped at all-ones.
    assign w_drop_sum = {2'b00, r_drop_cnt} + {{CNT_W{1'b0}}, r_occ};
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (flush_i) begin
            if (w_drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
                w_drop_nxt = {CNT_W{1'b1}};
            end else begin
                w_drop_nxt = w_drop_sum[CNT_W-1:0];
            end
        end
    end

    // Main register, occupancy and drop counter.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_occ        <= 2'd0;
            r_drop_cnt   <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_occ        <= w_occ_nxt;
            r_drop_cnt   <= w_drop_nxt;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_main_valid;
    assign bus.out_data_o  = r_main_data;
    assign occupancy_o     = r_occ;
    assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_reg_pipe_stage.sv
// tb_reg_pipe_stage -- self-checking bench for reg_pipe_stage. The reference
// model is a queue of held entries with a capacity of 2 (skid build) or 1.
module tb_reg_pipe_stage;
    localparam int DW = 32;
    localparam int CW = 8;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          flush2;
    logic [1:0]    occ;
    logic [CW-1:0] drop;
    logic [1:0]    occ2;
    logic [1:0]    drop2;

    reg_pipe_stage_if #(.DATA_W(DW)) bus ();
    reg_pipe_stage_if #(.DATA_W(DW)) bus2 ();

    reg_pipe_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .bus         (bus),
        .occupancy_o (occ),
        .drop_cnt_o  (drop)
    );

    reg_pipe_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(0), .CNT_W(2)) dut2 (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .flush_i     (flush2),
        .bus         (bus2),
        .occupancy_o (occ2),
        .drop_cnt_o  (drop2)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Scoreboard / reference model
    logic [DW-1:0] exp_q[$];
    int            model_drop;
    int            checks;
    int            failures;

    // One cycle: drive inputs, compare pre-edge outputs with the model,
    // advance the model, then cross the rising edge. Starts at posedge+1.
    task automatic step(input logic fl, input logic vin, input logic [DW-1:0] din,
                        input logic ordy, input string tag);
        logic exp_ready;
        logic exp_valid;
        int   sum;
        flush_i         = fl;
        bus.in_valid_i  = vin;
        bus.in_data_i   = din;
        bus.out_ready_i = ordy;
        #1;
        exp_valid = (exp_q.size() > 0);
        if (CAP == 2) exp_ready = (exp_q.size() < 2);
        else          exp_ready = (exp_q.size() == 0) || ordy;
        checks++;
        if (bus.out_valid_o !== exp_valid) begin
            failures++;
            $display("FAIL %s out_valid got=%0b exp=%0b", tag, bus.out_valid_o, exp_valid);
        end
        checks++;
        if (bus.in_ready_o !== exp_ready) begin
            failures++;
            $display("FAIL %s in_ready got=%0b exp=%0b", tag, bus.in_ready_o, exp_ready);
        end
        checks++;
        if (occ !== 2'(exp_q.size())) begin
            failures++;
            $display("FAIL %s occupancy got=%0d exp=%0d", tag, occ, exp_q.size());
        end
        checks++;
        if (drop !== CW'(model_drop)) begin
            failures++;
            $display("FAIL %s drop_cnt got=%0d exp=%0d", tag, drop, model_drop);
        end
        if (exp_valid) begin
            checks++;
            if (bus.out_data_o !== exp_q[0]) begin
                failures++;
                $display("FAIL %s out_data got=%h exp=%h", tag, bus.out_data_o, exp_q[0]);
            end
        end
        if (fl) begin
            sum = model_drop + exp_q.size();
            model_drop = (sum > (1 << CW) - 1) ? (1 << CW) - 1 : sum;
            exp_q.delete();
        end else begin
            if (exp_valid && ordy) void'(exp_q.pop_front());
            if (vin && exp_ready) exp_q.push_back(din);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i          = 1'b0;
        flush2           = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.out_ready_i  = 1'b0;
        bus2.in_valid_i  = 1'b0;
        bus2.in_data_i   = '0;
        bus2.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0 || occ !== 2'd0 || drop !== '0) begin
            failures++;
            $display("FAIL reset_dut v=%0b d=%h occ=%0d drop=%0d exp all zero",
                     bus.out_valid_o, bus.out_data_o, occ, drop);
        end
        checks++;
        if (bus2.out_valid_o !== 1'b0 || bus2.out_data_o !== '0 || occ2 !== 2'd0 || drop2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_dut2 v=%0b d=%h occ=%0d drop=%0d exp all zero",
                     bus2.out_valid_o, bus2.out_data_o, occ2, drop2);
        end
        #3 rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", bus.in_ready_o);
        end
        exp_q.delete();
        model_drop = 0;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, DW'(i), 1'b1, "stream");
        repeat (2) step(1'b0, 1'b0, '0, 1'b1, "stream_drain");
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, 32'hA, 1'b0, "bp_a");
        step(1'b0, 1'b1, 32'hB, 1'b0, "bp_b");
        step(1'b0, 1'b1, 32'hD, 1'b0, "bp_hold");
        step(1'b0, 1'b0, '0, 1'b0, "bp_hold2");
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, "bp_release");
    endtask

    task automatic test_flush();
        for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, DW'(32'h100 + i), 1'b0, "fl_fill");
        step(1'b1, 1'b1, 32'hC, 1'b0, "fl_edge");
        checks++;
        if (bus.out_data_o !== '0) begin
            failures++;
            $display("FAIL flush_clear out_data got=%h exp=0", bus.out_data_o);
        end
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, "fl_after");
        step(1'b1, 1'b0, '0, 1'b1, "fl_empty");
        step(1'b0, 1'b0, '0, 1'b1, "fl_empty_after");
    endtask

    task automatic test_saturation();
        logic [1:0]    exp_sat[5];
        logic [DW-1:0] d;
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            bus2.in_valid_i  = 1'b1;
            bus2.in_data_i   = d;
            bus2.out_ready_i = 1'b0;
            @(posedge clk_i);
            #1;
            bus2.in_valid_i = 1'b0;
            checks++;
            if (occ2 !== 2'd1) begin
                failures++;
                $display("FAIL sat_occ[%0d] got=%0d exp=1", i, occ2);
            end
            flush2 = 1'b1;
            @(posedge clk_i);
            #1;
            flush2 = 1'b0;
            checks++;
            if (drop2 !== exp_sat[i]) begin
                failures++;
                $display("FAIL sat_drop[%0d] got=%0d exp=%0d", i, drop2, exp_sat[i]);
            end
            checks++;
            if (bus2.out_valid_o !== 1'b0 || bus2.out_data_o !== d) begin
                failures++;
                $display("FAIL sat_keep[%0d] valid=%0b data=%h exp valid=0 data=%h",
                         i, bus2.out_valid_o, bus2.out_data_o, d);
            end
        end
    endtask

    task automatic test_random();
        logic          fl;
        logic          vin;
        logic          ordy;
        logic [DW-1:0] din;
        for (int i = 0; i < 400; i++) begin
            fl   = ($urandom_range(0, 19) == 0);
            vin  = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            din  = $urandom;
            step(fl, vin, din, ordy, "random");
        end
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, "random_drain");
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 32'h5A5A_0001, 1'b0, "ar_load");
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0 || occ !== 2'd0 || drop !== '0) begin
            failures++;
            $display("FAIL async_reset v=%0b d=%h occ=%0d drop=%0d exp all zero",
                     bus.out_valid_o, bus.out_data_o, occ, drop);
        end
        #3 rst_n = 1'b1;
        exp_q.delete();
        model_drop = 0;
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b1 || drop !== '0) begin
            failures++;
            $display("FAIL async_release ready=%0b drop=%0d exp ready=1 drop=0",
                     bus.in_ready_o, drop);
        end
        step(1'b0, 1'b0, '0, 1'b1, "ar_after");
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        model_drop = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
